// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU control codes, result and
// immediate source encodings, plus the immediate extension helper.
package rv_pkg;

  localparam int XLEN    = 32;
  localparam int NREGS   = 32;
  localparam int REG_AW  = $clog2(NREGS);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4
  } imm_src_e;

  // Everything the execute stage needs, captured in one flop bank.
  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic [1:0]        result_src;
    logic              alu_src;
    logic              branch;
    logic              jump;
    logic [2:0]        alu_control;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm_ext;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
  } idex_t;

  // Sign bit is always instr[31]; formats without an immediate yield zero.
  function automatic logic [XLEN-1:0] imm_extend(input logic [31:0] instr,
                                                 input imm_src_e    src);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (src)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_cycle_if.sv
// Signal bundle around the decode stage: IF/ID inputs, writeback port,
// flush, and the ID/EX outputs consumed by execute.
interface decode_cycle_if;
  import rv_pkg::*;

  logic [XLEN-1:0]   InstrD;
  logic [XLEN-1:0]   PCD;
  logic [XLEN-1:0]   PCPlus4D;
  logic              RegWriteW;
  logic [REG_AW-1:0] RDW;
  logic [XLEN-1:0]   ResultW;
  logic              FlushE;

  logic              RegWriteE;
  logic              MemWriteE;
  logic [1:0]        ResultSrcE;
  logic              ALUSrcE;
  logic              BranchE;
  logic              JumpE;
  logic [2:0]        ALUControlE;
  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   ImmExtE;
  logic [REG_AW-1:0] RS1E;
  logic [REG_AW-1:0] RS2E;
  logic [REG_AW-1:0] RDE;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;

  // Decode stage side.
  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    output RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE,
           ALUControlE, RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE, PCE, PCPlus4E
  );

  // Surrounding pipeline side (fetch, writeback, execute).
  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    input  RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE,
           ALUControlE, RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE, PCE, PCPlus4E
  );
endinterface

// File: rtl/decode_cycle_register_file.sv
// 31 GPRs with x0 hardwired to zero, two combinational read ports, one
// synchronous write port and same-cycle write-through to the readers.
module register_file
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              we,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data
);

  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic [XLEN-1:0] regs_d [1:NREGS-1];
  logic            wr_en;

  assign wr_en = we && (wr_addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // A pending write to the register being read wins over the stale entry.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0) begin
      rs1_data = (wr_en && (wr_addr == rs1_addr)) ? wr_data : regs_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != '0) begin
      rs2_data = (wr_en && (wr_addr == rs2_addr)) ? wr_data : regs_q[rs2_addr];
    end
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate extension,
// all captured into the ID/EX register one cycle later.
module decode_cycle
  import rv_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  decode_cycle_if.slave bus
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7_b5;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [REG_AW-1:0] rd_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;

  logic              reg_write;
  logic              mem_write;
  logic [1:0]        result_src;
  logic              alu_src;
  logic              branch;
  logic              jump;
  logic [2:0]        alu_control;
  imm_src_e          imm_src;

  idex_t             idex_d;
  idex_t             idex_q;

  assign opcode    = bus.InstrD[6:0];
  assign funct3    = bus.InstrD[14:12];
  assign funct7_b5 = bus.InstrD[30];
  assign rs1_addr  = bus.InstrD[19:15];
  assign rs2_addr  = bus.InstrD[24:20];
  assign rd_addr   = bus.InstrD[11:7];

  register_file u_register_file (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (bus.RegWriteW),
    .wr_addr  (bus.RDW),
    .wr_data  (bus.ResultW)
  );

  // Unknown opcodes fall through with every control bit low (NOP).
  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    result_src  = RES_ALU;
    alu_src     = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_control = ALU_ADD;
    imm_src     = IMM_NONE;
    case (opcode)
      OP_LOAD: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
        alu_src    = 1'b1;
        imm_src    = IMM_I;
      end
      OP_STORE: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_src   = IMM_S;
      end
      OP_RTYPE, OP_IALU: begin
        reg_write = 1'b1;
        alu_src   = (opcode == OP_IALU);
        imm_src   = (opcode == OP_IALU) ? IMM_I : IMM_NONE;
        case (funct3)
          3'b000:  alu_control = ((opcode == OP_RTYPE) && funct7_b5) ? ALU_SUB
                                                                     : ALU_ADD;
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          3'b010:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      OP_BRANCH: begin
        branch      = 1'b1;
        alu_control = ALU_SUB;
        imm_src     = IMM_B;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        result_src = RES_PC4;
        jump       = 1'b1;
        imm_src    = IMM_J;
      end
      default: begin
        reg_write = 1'b0;
      end
    endcase
  end

  // A flush turns the whole ID/EX slot into a bubble, data included.
  always_comb begin
    idex_d = '0;
    if (!bus.FlushE) begin
      idex_d.reg_write   = reg_write;
      idex_d.mem_write   = mem_write;
      idex_d.result_src  = result_src;
      idex_d.alu_src     = alu_src;
      idex_d.branch      = branch;
      idex_d.jump        = jump;
      idex_d.alu_control = alu_control;
      idex_d.rd1         = rs1_data;
      idex_d.rd2         = rs2_data;
      idex_d.imm_ext     = imm_extend(bus.InstrD, imm_src);
      idex_d.rs1         = rs1_addr;
      idex_d.rs2         = rs2_addr;
      idex_d.rd          = rd_addr;
      idex_d.pc          = bus.PCD;
      idex_d.pc_plus4    = bus.PCPlus4D;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign bus.RegWriteE   = idex_q.reg_write;
  assign bus.MemWriteE   = idex_q.mem_write;
  assign bus.ResultSrcE  = idex_q.result_src;
  assign bus.ALUSrcE     = idex_q.alu_src;
  assign bus.BranchE     = idex_q.branch;
  assign bus.JumpE       = idex_q.jump;
  assign bus.ALUControlE = idex_q.alu_control;
  assign bus.RD1E        = idex_q.rd1;
  assign bus.RD2E        = idex_q.rd2;
  assign bus.ImmExtE     = idex_q.imm_ext;
  assign bus.RS1E        = idex_q.rs1;
  assign bus.RS2E        = idex_q.rs2;
  assign bus.RDE         = idex_q.rd;
  assign bus.PCE         = idex_q.pc;
  assign bus.PCPlus4E    = idex_q.pc_plus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for the decode stage: reset, bypass, x0, branch/jump,
// flush, ALU decode, unknown opcodes and mid-stream reset.
module tb_decode_cycle;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  decode_cycle_if bus ();

  decode_cycle u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".RegWriteE"},   32'(bus.RegWriteE),   32'h0);
    check({tag, ".MemWriteE"},   32'(bus.MemWriteE),   32'h0);
    check({tag, ".ResultSrcE"},  32'(bus.ResultSrcE),  32'h0);
    check({tag, ".ALUSrcE"},     32'(bus.ALUSrcE),     32'h0);
    check({tag, ".BranchE"},     32'(bus.BranchE),     32'h0);
    check({tag, ".JumpE"},       32'(bus.JumpE),       32'h0);
    check({tag, ".ALUControlE"}, 32'(bus.ALUControlE), 32'h0);
    check({tag, ".RD1E"},        bus.RD1E,             32'h0);
    check({tag, ".RD2E"},        bus.RD2E,             32'h0);
    check({tag, ".ImmExtE"},     bus.ImmExtE,          32'h0);
    check({tag, ".RS1E"},        32'(bus.RS1E),        32'h0);
    check({tag, ".RS2E"},        32'(bus.RS2E),        32'h0);
    check({tag, ".RDE"},         32'(bus.RDE),         32'h0);
    check({tag, ".PCE"},         bus.PCE,              32'h0);
    check({tag, ".PCPlus4E"},    bus.PCPlus4E,         32'h0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst            = 1'b0;
    bus.InstrD     = 32'h00500093;  // addi x1,x0,5
    bus.PCD        = 32'h00000010;
    bus.PCPlus4D   = 32'h00000014;
    bus.RegWriteW  = 1'b0;
    bus.RDW        = 5'd0;
    bus.ResultW    = 32'h0;
    bus.FlushE     = 1'b0;

    // Reset held two cycles.
    step();
    step();
    check_all_zero("reset");

    rst = 1'b1;
    step();
    check("addi.RegWriteE",   32'(bus.RegWriteE),   32'h1);
    check("addi.ALUSrcE",     32'(bus.ALUSrcE),     32'h1);
    check("addi.ImmExtE",     bus.ImmExtE,          32'h5);
    check("addi.RDE",         32'(bus.RDE),         32'h1);
    check("addi.ALUControlE", 32'(bus.ALUControlE), 32'h0);
    check("addi.ResultSrcE",  32'(bus.ResultSrcE),  32'h0);
    check("addi.PCE",         bus.PCE,              32'h10);
    check("addi.PCPlus4E",    bus.PCPlus4E,         32'h14);

    // Write x1 in the same cycle add x2,x1,x1 reads it.
    bus.InstrD    = 32'h00108133;
    bus.RegWriteW = 1'b1;
    bus.RDW       = 5'd1;
    bus.ResultW   = 32'hDEADBEEF;
    step();
    check("bypass.RD1E",       bus.RD1E,             32'hDEADBEEF);
    check("bypass.RD2E",       bus.RD2E,             32'hDEADBEEF);
    check("bypass.RS1E",       32'(bus.RS1E),        32'h1);
    check("bypass.RS2E",       32'(bus.RS2E),        32'h1);
    check("bypass.RDE",        32'(bus.RDE),         32'h2);
    check("bypass.ALUSrcE",    32'(bus.ALUSrcE),     32'h0);
    check("bypass.RegWriteE",  32'(bus.RegWriteE),   32'h1);

    // Same read with no write pending must come from the array.
    bus.RegWriteW = 1'b0;
    bus.ResultW   = 32'h0;
    step();
    check("array.RD1E", bus.RD1E, 32'hDEADBEEF);
    check("array.RD2E", bus.RD2E, 32'hDEADBEEF);

    // Writes to x0 are dropped, also on the bypass path.
    bus.InstrD    = 32'h00700193;  // addi x3,x0,7
    bus.RegWriteW = 1'b1;
    bus.RDW       = 5'd0;
    bus.ResultW   = 32'h00001234;
    step();
    check("x0_bypass.RD1E",    bus.RD1E,    32'h0);
    check("x0_bypass.ImmExtE", bus.ImmExtE, 32'h7);
    bus.RegWriteW = 1'b0;
    step();
    check("x0_array.RD1E", bus.RD1E, 32'h0);

    bus.InstrD = 32'hFE000EE3;  // beq x0,x0,-4
    step();
    check("beq.BranchE",     32'(bus.BranchE),     32'h1);
    check("beq.ALUControlE", 32'(bus.ALUControlE), 32'h1);
    check("beq.ImmExtE",     bus.ImmExtE,          32'hFFFFFFFC);
    check("beq.RegWriteE",   32'(bus.RegWriteE),   32'h0);
    check("beq.ALUSrcE",     32'(bus.ALUSrcE),     32'h0);

    bus.InstrD = 32'h008000EF;  // jal x1,8
    step();
    check("jal.JumpE",      32'(bus.JumpE),      32'h1);
    check("jal.ResultSrcE", 32'(bus.ResultSrcE), 32'h2);
    check("jal.ImmExtE",    bus.ImmExtE,         32'h8);
    check("jal.RegWriteE",  32'(bus.RegWriteE),  32'h1);
    check("jal.BranchE",    32'(bus.BranchE),    32'h0);

    // Flushed sw; x5 is written by writeback in the same cycle.
    bus.InstrD    = 32'h0020A223;  // sw x2,4(x1)
    bus.PCD       = 32'h00000100;
    bus.PCPlus4D  = 32'h00000104;
    bus.FlushE    = 1'b1;
    bus.RegWriteW = 1'b1;
    bus.RDW       = 5'd5;
    bus.ResultW   = 32'h00000055;
    step();
    check_all_zero("flush");

    bus.FlushE    = 1'b0;
    bus.RegWriteW = 1'b0;
    step();
    check("sw.MemWriteE",   32'(bus.MemWriteE),   32'h1);
    check("sw.RegWriteE",   32'(bus.RegWriteE),   32'h0);
    check("sw.ImmExtE",     bus.ImmExtE,          32'h4);
    check("sw.ALUSrcE",     32'(bus.ALUSrcE),     32'h1);
    check("sw.ResultSrcE",  32'(bus.ResultSrcE),  32'h0);
    check("sw.RD1E",        bus.RD1E,             32'hDEADBEEF);
    check("sw.RS2E",        32'(bus.RS2E),        32'h2);
    check("sw.PCE",         bus.PCE,              32'h100);
    check("sw.PCPlus4E",    bus.PCPlus4E,         32'h104);

    bus.InstrD = 32'h0012E3B3;  // or x7,x5,x1
    step();
    check("or.RD1E",        bus.RD1E,             32'h55);
    check("or.RD2E",        bus.RD2E,             32'hDEADBEEF);
    check("or.ALUControlE", 32'(bus.ALUControlE), 32'h3);

    bus.InstrD = 32'h40508433;  // sub x8,x1,x5
    step();
    check("sub.ALUControlE", 32'(bus.ALUControlE), 32'h1);
    check("sub.RD2E",        bus.RD2E,             32'h55);

    bus.InstrD = 32'hFFF0A493;  // slti x9,x1,-1
    step();
    check("slti.ALUControlE", 32'(bus.ALUControlE), 32'h5);
    check("slti.ImmExtE",     bus.ImmExtE,          32'hFFFFFFFF);

    bus.InstrD = 32'h40000093;  // addi x1,x0,0x400: bit30 must not select sub
    step();
    check("addi_b30.ALUControlE", 32'(bus.ALUControlE), 32'h0);
    check("addi_b30.ImmExtE",     bus.ImmExtE,          32'h400);

    bus.InstrD = 32'h0000F033;  // and x0,x1,x0
    step();
    check("and.ALUControlE", 32'(bus.ALUControlE), 32'h2);

    bus.InstrD = 32'h00000000;
    step();
    check("nop0.RegWriteE",   32'(bus.RegWriteE),   32'h0);
    check("nop0.ImmExtE",     bus.ImmExtE,          32'h0);
    check("nop0.ALUControlE", 32'(bus.ALUControlE), 32'h0);

    bus.InstrD = 32'hFFFFFFFF;
    step();
    check("nop1.RegWriteE",  32'(bus.RegWriteE),  32'h0);
    check("nop1.MemWriteE",  32'(bus.MemWriteE),  32'h0);
    check("nop1.BranchE",    32'(bus.BranchE),    32'h0);
    check("nop1.JumpE",      32'(bus.JumpE),      32'h0);
    check("nop1.ImmExtE",    bus.ImmExtE,         32'h0);
    check("nop1.RS1E",       32'(bus.RS1E),       32'h1F);

    // Mid-stream reset with a live instruction and a pending write to x3.
    bus.InstrD    = 32'h00108133;
    bus.RegWriteW = 1'b1;
    bus.RDW       = 5'd3;
    bus.ResultW   = 32'h00000077;
    rst = 1'b0;
    step();
    check_all_zero("midreset");

    rst           = 1'b1;
    bus.RegWriteW = 1'b0;
    for (int i = 1; i < 32; i++) begin
      logic [31:0] instr;
      instr = ((32 - i) << 20) | (i << 15) | 32'h33;
      bus.InstrD = instr;
      step();
      check($sformatf("gpr_clear.x%0d", i),      bus.RD1E, 32'h0);
      check($sformatf("gpr_clear.x%0d", 32 - i), bus.RD2E, 32'h0);
    end

    bus.InstrD = 32'h0000A183;  // lw x3,0(x1)
    step();
    check("lw.ResultSrcE",  32'(bus.ResultSrcE),  32'h1);
    check("lw.RegWriteE",   32'(bus.RegWriteE),   32'h1);
    check("lw.ALUSrcE",     32'(bus.ALUSrcE),     32'h1);
    check("lw.MemWriteE",   32'(bus.MemWriteE),   32'h0);
    check("lw.RDE",         32'(bus.RDE),         32'h3);
    check("lw.RD1E",        bus.RD1E,             32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Second pipeline stage of the 5-stage RV32I core. Sits directly downstream of the fetch stage and consumes InstrD, PCD and PCPlus4D.
- Decodes the instruction, reads the 32x32 register file, extends the immediate, and registers everything into the ID/EX pipeline register for the execute stage.
- Owns the register file write port, which is driven from writeback.

Parameters:
- XLEN, 32, datapath width
- NREGS, 32, number of architectural registers; x0 is hardwired to zero

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- InstrD  in  32  instruction from the IF/ID register
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PC+4 of InstrD
- RegWriteW  in  1  writeback write enable
- RDW  in  5  writeback destination register
- ResultW  in  32  writeback data
- FlushE  in  1  insert a bubble into ID/EX (taken branch or jump resolved in EX)
- RegWriteE  out  1  register write enable
- MemWriteE  out  1  data memory write
- ResultSrcE  out  2  result select: 00 ALU, 01 memory, 10 PC+4
- ALUSrcE  out  1  ALU operand B select: 0 RD2, 1 immediate
- BranchE  out  1  beq
- JumpE  out  1  jal
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1E, RD2E  out  32  register operands
- ImmExtE  out  32  sign-extended immediate
- RS1E, RS2E, RDE  out  5  register indices, used for forwarding
- PCE, PCPlus4E  out  32  forwarded PC values

Behaviour:
- Reset: on a clk edge with rst==0, every output register and all 31 GPRs clear to 0. No asynchronous path and no combinational masking of outputs by rst. Outputs are driven directly by flops.
- Latency: exactly 1 cycle. Fields decoded from InstrD in cycle N appear on the E outputs in cycle N+1.
- Register file:
  - Write on the rising edge when RegWriteW==1 and RDW!=0.
  - Writes to x0 are ignored. Reads of x0 always return 0.
- Write-through bypass: if RegWriteW==1, RDW!=0, and RDW equals rs1 (or rs2), the read returns ResultW in the same cycle, not the stale array value.
- Decode by opcode (RegWrite, MemWrite, ResultSrc, ALUSrc, Branch, Jump, ImmSrc):
  - 0000011 lw: 1, 0, 01, 1, 0, 0, I
  - 0100011 sw: 0, 1, xx (drive 00), 1, 0, 0, S
  - 0110011 R-type: 1, 0, 00, 0, 0, 0, n/a
  - 0010011 I-ALU: 1, 0, 00, 1, 0, 0, I
  - 1100011 beq: 0, 0, 00, 0, 1, 0, B
  - 1101111 jal: 1, 0, 10, 0, 0, 1, J
- ALUOp and ALUControl:
  - lw and sw use add.
  - beq uses sub.
  - R-type and I-ALU decode by funct3/funct7[5]: 000 gives add, or sub when R-type and funct7[5]==1; 111 and; 110 or; 010 slt.
  - Any other funct3 gives add.
- Immediates:
  - I = sext(instr[31:20])
  - S = sext({instr[31:25], instr[11:7]})
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})
  - Sign bit is always instr[31].
- Unknown opcode (including 0x00000000): all control outputs 0, ImmExtE 0. The instruction behaves as a NOP.
- FlushE==1 at an edge: control outputs (RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE, ALUControlE) load 0. Data and index outputs also load 0.
- Priority: reset > FlushE > normal load.
- Register file writes still occur during FlushE. Register file writes do not occur during reset, which clears the array instead.
- rst deasserted with InstrD==0: pipeline fills with NOPs and no register is written.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_IALU, OP_BRANCH, OP_JAL)
  - ALU control codes
  - ResultSrc encodings
  - ImmSrc encodings (IMM_I, IMM_S, IMM_B, IMM_J)
- Sub-module register_file: two combinational read ports, one synchronous write port, x0 hardwired, and the write-through bypass.
- Control decode and immediate extension stay inline in decode_cycle.

Test Plan:
- Hold rst=0 for 2 cycles with InstrD=0x00500093 -> all E outputs 0. After release, RegWriteE=1, ALUSrcE=1, ImmExtE=5, RDE=1, ALUControlE=000.
- Write x1=0xDEADBEEF via writeback while InstrD=0x00108133 (add x2,x1,x1) in the same cycle -> next cycle RD1E=RD2E=0xDEADBEEF (bypass check).
- RegWriteW=1, RDW=0, ResultW=0x1234, then decode an instruction reading x0 -> RD1E=0.
- InstrD=0xFE000EE3 (beq x0,x0,-4) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC. InstrD=0x008000EF (jal x1,8) -> JumpE=1, ResultSrcE=10, ImmExtE=8.
- InstrD=0x0020A223 (sw x2,4(x1)) with FlushE=1 -> all E outputs 0. With FlushE=0 next cycle -> MemWriteE=1, RegWriteE=0, ImmExtE=4.
- Mid-stream rst=0 with valid instructions in flight -> all outputs and all GPRs read 0 after the edge. A following lw (0x0000A183) decodes ResultSrcE=01.
